// File: rtl/tlp_fc_pkg.sv
// ---------------------------------------------------------------------------
// tlp_fc_pkg
// Shared definitions for the VC0 credit gate:
//   - tlp_class_e    : flow-control class of a TLP (P / NP / CPL / unsupported)
//   - TYPE_* consts  : TLP type-field encodings used by the classifier
//   - credit_ok()    : modular credit test against an advertised limit
// ---------------------------------------------------------------------------
package tlp_fc_pkg;

    localparam int FC_CREDIT_W = 10;
    // ceil(1024/4) = 256 needs 9 bits
    localparam int DATA_REQ_W  = 9;

    typedef enum logic [1:0] {
        CLS_P     = 2'd0,
        CLS_NP    = 2'd1,
        CLS_CPL   = 2'd2,
        CLS_UNSUP = 2'd3
    } tlp_class_e;

    localparam logic [4:0] TYPE_MEM     = 5'b00000;
    localparam logic [4:0] TYPE_IO      = 5'b00010;
    localparam logic [4:0] TYPE_CPL     = 5'b01010;
    localparam logic [1:0] TYPE_MSG_PFX = 2'b10;
    localparam logic [3:0] TYPE_CFG_PFX = 4'b0010;

    localparam logic [FC_CREDIT_W-1:0] FC_HALF = {1'b1, {(FC_CREDIT_W-1){1'b0}}};

    // Credits are free-running counters, so the test is done on the modular
    // gap between limit and what consumption would become. A gap in the
    // lower half of the ring (including exactly half) means enough credit.
    function automatic logic credit_ok(input logic [FC_CREDIT_W-1:0] limit,
                                       input logic [FC_CREDIT_W-1:0] consumed,
                                       input logic [FC_CREDIT_W-1:0] req);
        logic [FC_CREDIT_W-1:0] gap;
        gap = limit - (consumed + req);
        return (gap <= FC_HALF);
    endfunction

endpackage

// File: rtl/tlp_classifier.sv
// ---------------------------------------------------------------------------
// tlp_classifier (combinational)
// Decodes DW0 of a TLP header into its flow-control class and the number of
// data credits (16-byte units) its payload needs.
// Ports:
//   dw0      in   32          first header double-word
//   cls      out  tlp_class_e P / NP / CPL / UNSUP
//   data_req out  DATA_REQ_W  ceil(len/4) when fmt[1]=1, else 0
// ---------------------------------------------------------------------------
module tlp_classifier
    import tlp_fc_pkg::*;
(
    input  logic [31:0]           dw0,
    output tlp_class_e            cls,
    output logic [DATA_REQ_W-1:0] data_req
);

    logic       has_data;
    logic [4:0] tlp_type;
    logic [9:0] len;
    logic [10:0] len_dw;
    logic       unused_dw0_bits;

    assign unused_dw0_bits = ^{dw0[31], dw0[29], dw0[23:10]};

    always_comb begin
        has_data = dw0[30];
        tlp_type = dw0[28:24];
        len      = dw0[9:0];
        // a zero length field encodes the maximum of 1024 DW
        len_dw   = (len == 10'd0) ? 11'd1024 : {1'b0, len};

        cls = CLS_UNSUP;
        if (tlp_type == TYPE_MEM) begin
            cls = has_data ? CLS_P : CLS_NP;
        end else if (tlp_type[4:3] == TYPE_MSG_PFX) begin
            cls = CLS_P;
        end else if ((tlp_type == TYPE_IO) || (tlp_type[4:1] == TYPE_CFG_PFX)) begin
            cls = CLS_NP;
        end else if (tlp_type == TYPE_CPL) begin
            cls = CLS_CPL;
        end

        data_req = '0;
        if (has_data) begin
            data_req = DATA_REQ_W'((len_dw + 11'd3) >> 2);
        end
    end

endmodule

// File: rtl/tlp_credit_gate.sv
// ---------------------------------------------------------------------------
// tlp_credit_gate
// Holds one TLP beat at a time and forwards it to the VC0 TX element only
// when the advertised header and data credits cover it, then advances the
// matching credits-consumed counters on the output handshake.
//
// Handshakes (both sides): a beat moves when valid and ready are high in the
// same cycle; valid never drops and data never changes while waiting for
// ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/valid/ready input beat (one beat = one TLP, DW0 in the MSBs)
//   *_credit_limit      advertised limits (PH, PD, NPH, NPD, CH, CD)
//   out_data/valid/ready forwarded beat towards the TX element
//   blocked, blocked_type  held TLP is waiting for credit, and its class
//   err_unsupported     one-cycle pulse: beat dropped as unsupported
//   *_consumed          credits-consumed counters (wrap mod 2^CREDIT_W)
//   dbg_state           current FSM state
// CREDIT_W must equal tlp_fc_pkg::FC_CREDIT_W (credit_ok operates on it).
// ---------------------------------------------------------------------------
module tlp_credit_gate
    import tlp_fc_pkg::*;
#(
    parameter int CREDIT_W   = FC_CREDIT_W,
    parameter int BYTES      = 8,
    parameter int DW         = 4 * BYTES,
    parameter int DATA_WIDTH = 5 * DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CREDIT_W-1:0]   ph_credit_limit,
    input  logic [CREDIT_W-1:0]   pd_credit_limit,
    input  logic [CREDIT_W-1:0]   nph_credit_limit,
    input  logic [CREDIT_W-1:0]   npd_credit_limit,
    input  logic [CREDIT_W-1:0]   ch_credit_limit,
    input  logic [CREDIT_W-1:0]   cd_credit_limit,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  blocked,
    output logic [1:0]            blocked_type,
    output logic                  err_unsupported,
    output logic [CREDIT_W-1:0]   ph_consumed,
    output logic [CREDIT_W-1:0]   pd_consumed,
    output logic [CREDIT_W-1:0]   nph_consumed,
    output logic [CREDIT_W-1:0]   npd_consumed,
    output logic [CREDIT_W-1:0]   ch_consumed,
    output logic [CREDIT_W-1:0]   cd_consumed,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam logic [CREDIT_W-1:0] HDR_REQ = CREDIT_W'(1);

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] beat_q;
    tlp_class_e            cls_q;
    logic [CREDIT_W-1:0]   data_req_q;
    logic                  err_q;

    tlp_class_e            cls_c;
    logic [DATA_REQ_W-1:0] data_req_c;

    tlp_classifier u_classifier (
        .dw0      (beat_q[DATA_WIDTH-1 -: 32]),
        .cls      (cls_c),
        .data_req (data_req_c)
    );

    // In CHECK the decode is still combinational from the held beat; in WAIT
    // the registered decode is reused so the test runs every cycle.
    tlp_class_e          eval_cls;
    logic [CREDIT_W-1:0] eval_dreq;
    logic [CREDIT_W-1:0] hdr_lim, hdr_cons, dat_lim, dat_cons;
    logic                hdr_ok, dat_ok, credit_pass;

    always_comb begin
        eval_cls  = (state == ST_CHECK) ? cls_c : cls_q;
        eval_dreq = (state == ST_CHECK) ? CREDIT_W'(data_req_c) : data_req_q;

        hdr_lim  = '0;
        hdr_cons = '0;
        dat_lim  = '0;
        dat_cons = '0;
        case (eval_cls)
            CLS_P: begin
                hdr_lim = ph_credit_limit;  hdr_cons = ph_consumed;
                dat_lim = pd_credit_limit;  dat_cons = pd_consumed;
            end
            CLS_NP: begin
                hdr_lim = nph_credit_limit; hdr_cons = nph_consumed;
                dat_lim = npd_credit_limit; dat_cons = npd_consumed;
            end
            CLS_CPL: begin
                hdr_lim = ch_credit_limit;  hdr_cons = ch_consumed;
                dat_lim = cd_credit_limit;  dat_cons = cd_consumed;
            end
            default: ;
        endcase

        hdr_ok      = credit_ok(hdr_lim, hdr_cons, HDR_REQ);
        // payload-less TLPs never look at the data credit pool
        dat_ok      = (eval_dreq == '0) || credit_ok(dat_lim, dat_cons, eval_dreq);
        credit_pass = hdr_ok && dat_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            beat_q       <= '0;
            cls_q        <= CLS_P;
            data_req_q   <= '0;
            err_q        <= 1'b0;
            ph_consumed  <= '0;
            pd_consumed  <= '0;
            nph_consumed <= '0;
            npd_consumed <= '0;
            ch_consumed  <= '0;
            cd_consumed  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        beat_q <= in_data;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    cls_q      <= cls_c;
                    data_req_q <= CREDIT_W'(data_req_c);
                    if (cls_c == CLS_UNSUP) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else if (credit_pass) begin
                        state <= ST_SEND;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (credit_pass) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // grant is already committed; limits are not rechecked here
                    if (out_ready) begin
                        case (cls_q)
                            CLS_P: begin
                                ph_consumed <= ph_consumed + HDR_REQ;
                                pd_consumed <= pd_consumed + data_req_q;
                            end
                            CLS_NP: begin
                                nph_consumed <= nph_consumed + HDR_REQ;
                                npd_consumed <= npd_consumed + data_req_q;
                            end
                            CLS_CPL: begin
                                ch_consumed <= ch_consumed + HDR_REQ;
                                cd_consumed <= cd_consumed + data_req_q;
                            end
                            default: ;
                        endcase
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready        = (state == ST_IDLE);
    assign out_valid       = (state == ST_SEND);
    assign out_data        = beat_q;
    assign blocked         = (state == ST_WAIT);
    assign blocked_type    = blocked ? 2'(cls_q) : 2'd0;
    assign err_unsupported = err_q;
    assign dbg_state       = state;

endmodule
